// File: rtl/status_stack.sv
// Processor status unit: Z/N (optionally C/V) flag register plus a small LIFO
// for saving and restoring flags. Define STATUS_CV_FLAGS_EN to store C/V as well.
module status_stack #(
  parameter int DATA_WIDTH  = 16,
  parameter int STACK_DEPTH = 4,
  localparam int CNT_W      = $clog2(STACK_DEPTH + 1)
) (
  input  logic                  clock,
  input  logic                  status_reset,
  input  logic                  status_wr,
  input  logic [DATA_WIDTH-1:0] result_in,
  input  logic                  carry_in,
  input  logic                  overflow_in,
  input  logic                  status_push,
  input  logic                  status_pop,
  output logic                  flag_Z,
  output logic                  flag_N,
  output logic                  flag_C,
  output logic                  flag_V,
  output logic [CNT_W-1:0]      stack_count,
  output logic                  stack_full,
  output logic                  stack_empty,
  output logic                  stack_error
);

`ifdef STATUS_CV_FLAGS_EN
  localparam int ENT_W = 4;
`else
  localparam int ENT_W = 2;
`endif

  // Index width sized so the storage array is fully addressable without range gaps.
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam int ARR_D = 1 << IDX_W;

  // Flag set packing: bit0 = Z, bit1 = N, bit2 = C, bit3 = V.
  logic [ENT_W-1:0] r_flags;
  logic [ENT_W-1:0] r_stack [0:ARR_D-1];
  logic [CNT_W-1:0] r_count;
  logic             r_full;
  logic             r_empty;
  logic             r_error;

  logic [ENT_W-1:0] w_new_flags;
  logic [ENT_W-1:0] w_flags_nxt;
  logic [CNT_W-1:0] w_count_nxt;
  logic [CNT_W-1:0] w_count_m1;
  logic [IDX_W-1:0] w_push_idx;
  logic [IDX_W-1:0] w_pop_idx;
  logic             w_both;
  logic             w_push_full;
  logic             w_pop_empty;
  logic             w_illegal;
  logic             w_do_push;
  logic             w_do_pop;

`ifdef STATUS_CV_FLAGS_EN
  assign w_new_flags = {overflow_in, carry_in, result_in[DATA_WIDTH-1], ~|result_in};
`else
  logic w_unused_cv;
  assign w_unused_cv = carry_in ^ overflow_in;
  assign w_new_flags = {result_in[DATA_WIDTH-1], ~|result_in};
`endif

  assign w_both      = status_push & status_pop;
  assign w_push_full = status_push & ~status_pop & r_full;
  assign w_pop_empty = status_pop & ~status_push & r_empty;
  assign w_illegal   = w_both | w_push_full | w_pop_empty;
  assign w_do_push   = status_push & ~status_pop & ~r_full;
  assign w_do_pop    = status_pop & ~status_push & ~r_empty;

  assign w_count_m1  = r_count - CNT_W'(1);
  assign w_push_idx  = r_count[IDX_W-1:0];
  assign w_pop_idx   = w_count_m1[IDX_W-1:0];

  always_comb begin
    w_flags_nxt = r_flags;
    if (w_do_pop) begin
      w_flags_nxt = r_stack[w_pop_idx];
    end else if (status_wr) begin
      w_flags_nxt = w_new_flags;
    end
  end

  always_comb begin
    w_count_nxt = r_count;
    if (w_do_push) begin
      w_count_nxt = r_count + CNT_W'(1);
    end else if (w_do_pop) begin
      w_count_nxt = w_count_m1;
    end
  end

  always_ff @(posedge clock) begin
    if (status_reset) begin
      r_flags <= '0;
      r_count <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
      r_error <= 1'b0;
    end else begin
      r_flags <= w_flags_nxt;
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == CNT_W'(STACK_DEPTH));
      r_empty <= (w_count_nxt == '0);
      r_error <= r_error | w_illegal;
    end
  end

  // Entries are never cleared; a zeroed count makes stale data unreachable.
  always_ff @(posedge clock) begin
    if (!status_reset && w_do_push) begin
      r_stack[w_push_idx] <= r_flags;
    end
  end

  assign flag_Z = r_flags[0];
  assign flag_N = r_flags[1];
`ifdef STATUS_CV_FLAGS_EN
  assign flag_C = r_flags[2];
  assign flag_V = r_flags[3];
`else
  assign flag_C = 1'b0;
  assign flag_V = 1'b0;
`endif

  assign stack_count = r_count;
  assign stack_full  = r_full;
  assign stack_empty = r_empty;
  assign stack_error = r_error;

endmodule

// File: tb/tb_status_stack.sv
// Self-checking bench for status_stack: directed steps then random traffic,
// compared against a queue-based reference model of the flag stack.
module tb_status_stack;
  localparam int DW    = 16;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clock;
  logic          status_reset, status_wr, carry_in, overflow_in, status_push, status_pop;
  logic [DW-1:0] result_in;
  logic          flag_Z, flag_N, flag_C, flag_V;
  logic [CW-1:0] stack_count;
  logic          stack_full, stack_empty, stack_error;

  status_stack #(.DATA_WIDTH(DW), .STACK_DEPTH(DEPTH)) dut (
    .clock(clock), .status_reset(status_reset), .status_wr(status_wr),
    .result_in(result_in), .carry_in(carry_in), .overflow_in(overflow_in),
    .status_push(status_push), .status_pop(status_pop),
    .flag_Z(flag_Z), .flag_N(flag_N), .flag_C(flag_C), .flag_V(flag_V),
    .stack_count(stack_count), .stack_full(stack_full),
    .stack_empty(stack_empty), .stack_error(stack_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: flags as {V,C,N,Z}, stack as a queue (back = top).
  logic [3:0] m_flags;
  logic [3:0] m_q[$];
  logic       m_err;

  function automatic logic [3:0] derive(input logic [DW-1:0] r, input logic c, input logic v);
`ifdef STATUS_CV_FLAGS_EN
    return {v, c, r[DW-1], (r == 0)};
`else
    return {1'b0, 1'b0, r[DW-1], (r == 0)};
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".Z"},     32'(flag_Z), 32'(m_flags[0]));
    chk({tag, ".N"},     32'(flag_N), 32'(m_flags[1]));
    chk({tag, ".C"},     32'(flag_C), 32'(m_flags[2]));
    chk({tag, ".V"},     32'(flag_V), 32'(m_flags[3]));
    chk({tag, ".count"}, 32'(stack_count), 32'(m_q.size()));
    chk({tag, ".full"},  32'(stack_full), 32'(m_q.size() == DEPTH));
    chk({tag, ".empty"}, 32'(stack_empty), 32'(m_q.size() == 0));
    chk({tag, ".error"}, 32'(stack_error), 32'(m_err));
  endtask

  task automatic step(input string tag, input logic rst, input logic wr, input logic push,
                      input logic pop, input logic [DW-1:0] res, input logic c, input logic v);
    status_reset = rst; status_wr = wr; status_push = push; status_pop = pop;
    result_in = res; carry_in = c; overflow_in = v;
    @(posedge clock);
    if (rst) begin
      m_flags = '0; m_q.delete(); m_err = 1'b0;
    end else if (push && pop) begin
      m_err = 1'b1;
      if (wr) m_flags = derive(res, c, v);
    end else if (push) begin
      if (m_q.size() == DEPTH) m_err = 1'b1;
      else m_q.push_back(m_flags);
      if (wr) m_flags = derive(res, c, v);
    end else if (pop) begin
      if (m_q.size() == 0) begin
        m_err = 1'b1;
        if (wr) m_flags = derive(res, c, v);
      end else begin
        m_flags = m_q.pop_back();
      end
    end else if (wr) begin
      m_flags = derive(res, c, v);
    end
    #1;
    check_all(tag);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    m_flags = '0; m_err = 1'b0;
    status_reset = 1'b1; status_wr = 1'b0; status_push = 1'b0; status_pop = 1'b0;
    result_in = '0; carry_in = 1'b0; overflow_in = 1'b0;
    @(negedge clock);

    step("reset",     1, 0, 0, 0, 16'h0000, 0, 0);
    step("wr_zero",   0, 1, 0, 0, 16'h0000, 0, 0);
    step("wr_8001",   0, 1, 0, 0, 16'h8001, 1, 0);
    step("wr_zero2",  0, 1, 0, 0, 16'h0000, 0, 0);
    step("push_wr",   0, 1, 1, 0, 16'h8000, 0, 1);
    step("pop_back",  0, 0, 0, 1, 16'h0000, 0, 0);
    // Fill with distinct sets, then overflow
    step("f0",        0, 1, 0, 0, 16'h0000, 0, 0);
    step("push0",     0, 1, 1, 0, 16'h8000, 1, 0);
    step("push1",     0, 1, 1, 0, 16'h1234, 0, 1);
    step("push2",     0, 1, 1, 0, 16'hC000, 1, 1);
    step("push3",     0, 0, 1, 0, 16'h0000, 0, 0);
    step("push_full", 0, 1, 1, 0, 16'h0001, 1, 0);
    step("pop3",      0, 0, 0, 1, 16'h0000, 0, 0);
    step("pop2",      0, 0, 0, 1, 16'h0000, 0, 0);
    step("pop1",      0, 0, 0, 1, 16'h0000, 0, 0);
    step("pop0",      0, 0, 0, 1, 16'h0000, 0, 0);
    step("rst2",      1, 0, 0, 0, 16'h0000, 0, 0);
    step("pop_empty", 0, 1, 0, 1, 16'h0000, 1, 1);
    step("rst3",      1, 0, 0, 0, 16'h0000, 0, 0);
    step("pp_a",      0, 1, 1, 0, 16'h8000, 0, 0);
    step("pp_b",      0, 0, 1, 0, 16'h0000, 0, 0);
    step("push_pop",  0, 0, 1, 1, 16'h0000, 0, 0);
    step("pp_c",      0, 1, 1, 0, 16'h0007, 1, 0);
    step("rst_mid",   1, 1, 1, 0, 16'h0000, 1, 1);
    step("wr_after",  0, 1, 0, 0, 16'hFFFF, 1, 1);

    for (int i = 0; i < 600; i++) begin
      logic rst, wr, push, pop, c, v;
      logic [DW-1:0] res;
      rst  = ($urandom_range(0, 49) == 0);
      wr   = $urandom_range(0, 1);
      push = ($urandom_range(0, 2) == 0);
      pop  = ($urandom_range(0, 2) == 0);
      res  = ($urandom_range(0, 3) == 0) ? '0 : DW'($urandom);
      c    = $urandom_range(0, 1);
      v    = $urandom_range(0, 1);
      step("rand", rst, wr, push, pop, res, c, v);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
